fetch_queue: RTL

//   Instruction-fetch front end that sits directly upstream of the instruction decoder.
//   - Owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid protocol.
//   - Buffers returned words in order and presents {inst, pc} to decode with valid/ready.
//   - Handles branch/jump redirects by flushing queued words and discarding responses still in flight.

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 103 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory req/gnt/rvalid side,
// redirect input from execute, and valid/ready output toward decode.
// Ports (master = fetch_queue view):
//   out: im_req, im_addr, id_valid, id_inst, id_pc
//   in : im_gnt, im_rvalid, im_rdata, redirect, redirect_pc, id_ready
interface fetch_queue_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    modport master (
        output im_req, im_addr, id_valid, id_inst, id_pc,
        input  im_gnt, im_rvalid, im_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  im_req, im_addr, id_valid, id_inst, id_pc,
        output im_gnt, im_rvalid, im_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited
// requests to instruction memory, buffers returned words in order and
// presents {inst, pc} to decode. Redirects flush the queue and drop
// responses still in flight.
// Ports: clk, rst (async, active-high), bus (fetch_queue_if.master).
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   inst_q [QDEPTH];
    logic [31:0]   pc_q   [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic          run;

    logic          rsp;
    logic          credit;
    logic          req;
    logic          issue;
    logic          push;
    logic          pop;
    logic          valid;
    logic [31:0]   target;

    // A response with nothing outstanding is stray and must not count.
    assign rsp    = bus.im_rvalid && (outst != '0);
    assign credit = ({1'b0, outst} + {1'b0, count}) < (CW + 1)'(QDEPTH);
    // run holds im_req low until the first edge after reset release.
    assign req    = run && !bus.redirect && credit;
    assign issue  = req && bus.im_gnt;
    assign push   = rsp && (drop_cnt == '0) && !bus.redirect;
    assign valid  = (count != '0);
    assign pop    = valid && bus.id_ready && !bus.redirect;
    assign target = {bus.redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            drop_cnt <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            run   <= 1'b1;
            outst <= outst + CW'(issue) - CW'(rsp);
            if (bus.redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                drop_cnt <= outst - CW'(rsp);
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    tail    <= tail + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset; count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[tail] <= bus.im_rdata;
            pc_q[tail]   <= resp_pc;
        end
    end

    assign bus.im_req   = req;
    assign bus.im_addr  = fetch_pc;
    assign bus.id_valid = valid;
    assign bus.id_inst  = valid ? inst_q[head] : NOP_INST;
    assign bus.id_pc    = valid ? pc_q[head] : 32'd0;

endmodule
